// File: rtl/dram_arbiter.sv
// dram_arbiter: two-port round-robin arbiter and access sequencer in front of
// the word-only data RAM. Port 0 is the load/store unit, port 1 a second
// master (DMA/debug). Each grant becomes one RAM access cycle, plus a merge
// cycle for byte-enable writes when read-modify-write is compiled in.
// Build option: define DRAM_ARB_RMW_EN to enable the ACCESS+MERGE
// read-modify-write path for partial byte enables; without it any write with
// a non-zero byte enable is a full-word write.
module dram_arbiter #(
  parameter int RAM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS
`ifdef DRAM_ARB_RMW_EN
    ,
    ST_MERGE
`endif
  } state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_port;
  logic        r_we;
`ifdef DRAM_ARB_RMW_EN
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] w_mask;
  logic [31:0] w_merged;
`endif

  logic        w_pick1;
  logic        w_we;
  logic [3:0]  w_be;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_full;
  logic        w_unused;

  // The RAM index wraps by itself and the byte offset is dropped, so these
  // bits and the depth parameter have no effect on the sequencing logic.
  assign w_unused = &{1'b0, m0_addr[1:0], m1_addr[1:0], (RAM_WORDS > 0)};

  // Winner selection: a lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    w_pick1 = m1_req;
    if (m0_req && m1_req) begin
      w_pick1 = ~r_last;
    end
  end

  assign w_we    = w_pick1 ? m1_we    : m0_we;
  assign w_be    = w_pick1 ? m1_be    : m0_be;
  assign w_addr  = w_pick1 ? m1_addr  : m0_addr;
  assign w_wdata = w_pick1 ? m1_wdata : m0_wdata;

`ifdef DRAM_ARB_RMW_EN
  // Only a complete byte mask can be written in the ACCESS cycle.
  assign w_full = (w_be == 4'hF);

  // Expand the latched byte enables into a bit mask for the merge.
  assign w_mask = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};

  // Enabled bytes come from the requester, the rest from the word just read.
  assign w_merged = (r_wdata & w_mask) | (ram_rdata & ~w_mask);
`else
  // Without read-modify-write any non-empty mask writes the whole word.
  assign w_full = (w_be != 4'h0);
`endif

  // Main sequencer: grant in IDLE, drive the RAM in ACCESS/MERGE, registered outputs throughout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_last    <= 1'b1;
      r_port    <= 1'b0;
      r_we      <= 1'b0;
`ifdef DRAM_ARB_RMW_EN
      r_be      <= 4'h0;
      r_wdata   <= 32'h0;
`endif
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
      m0_rdata  <= 32'h0;
      m1_rdata  <= 32'h0;
      ram_we    <= 1'b0;
      ram_addr  <= 32'h0;
      ram_wdata <= 32'h0;
    end else begin
      m0_gnt  <= 1'b0;
      m1_gnt  <= 1'b0;
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      ram_we  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            r_port    <= w_pick1;
            r_last    <= w_pick1;
            r_we      <= w_we;
`ifdef DRAM_ARB_RMW_EN
            r_be      <= w_be;
            r_wdata   <= w_wdata;
`endif
            ram_addr  <= {w_addr[31:2], 2'b00};
            ram_wdata <= w_wdata;
            ram_we    <= w_we && w_full;
            if (w_pick1) begin
              m1_gnt <= 1'b1;
            end else begin
              m0_gnt <= 1'b1;
            end
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!r_we) begin
            if (r_port) begin
              m1_rdata <= ram_rdata;
              m1_done  <= 1'b1;
            end else begin
              m0_rdata <= ram_rdata;
              m0_done  <= 1'b1;
            end
            r_state <= ST_IDLE;
          end
`ifdef DRAM_ARB_RMW_EN
          else if ((r_be != 4'h0) && (r_be != 4'hF)) begin
            ram_wdata <= w_merged;
            ram_we    <= 1'b1;
            r_state   <= ST_MERGE;
          end
`endif
          else begin
            if (r_port) begin
              m1_done <= 1'b1;
            end else begin
              m0_done <= 1'b1;
            end
            r_state <= ST_IDLE;
          end
        end
`ifdef DRAM_ARB_RMW_EN
        ST_MERGE: begin
          if (r_port) begin
            m1_done <= 1'b1;
          end else begin
            m0_done <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
`endif
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed and randomized checks of dram_arbiter against a
// transaction-level model of arbitration, latency and RAM contents.
module tb_dram_arbiter;

`ifdef DRAM_ARB_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req;
  logic        weIn [2];
  logic [3:0]  beIn [2];
  logic [31:0] addrIn [2];
  logic [31:0] wdataIn [2];

  logic        m0_gnt, m0_done, m1_gnt, m1_done;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ramWe;
  logic [31:0] ramAddr, ramWdata, ramRdata;

  logic [31:0] ram   [0:1023];
  logic [31:0] model [0:1023];

  int          checkCount = 0;
  int          passCount = 0;

  int          cyc = 0;
  int          freeAt = 0;
  int          gntAt = -1;
  int          gntPort = 0;
  int          weAt = -1;
  int          wrAt = -1;
  int          wrIdx = 0;
  bit          wrValid = 1'b0;
  logic [31:0] wrData;
  bit          lastPort = 1'b1;
  int          doneAt [2];
  bit          doneRead [2];
  logic [31:0] expRd [2];
  logic [31:0] heldRd [2];
  logic [31:0] expWAddr, expWData;
  bit          busy [2];
  txn_t        pend [2];
  bit          randomOn = 1'b0;
  bit          weSeen = 1'b0;
  logic [1:0]  reqPrev;
  int          gntLog [$];

  always #5 clk = ~clk;

  dram_arbiter #(.RAM_WORDS(1024)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req    (req[0]),
    .m0_we     (weIn[0]),
    .m0_be     (beIn[0]),
    .m0_addr   (addrIn[0]),
    .m0_wdata  (wdataIn[0]),
    .m0_gnt    (m0_gnt),
    .m0_done   (m0_done),
    .m0_rdata  (m0_rdata),
    .m1_req    (req[1]),
    .m1_we     (weIn[1]),
    .m1_be     (beIn[1]),
    .m1_addr   (addrIn[1]),
    .m1_wdata  (wdataIn[1]),
    .m1_gnt    (m1_gnt),
    .m1_done   (m1_done),
    .m1_rdata  (m1_rdata),
    .ram_we    (ramWe),
    .ram_addr  (ramAddr),
    .ram_wdata (ramWdata),
    .ram_rdata (ramRdata)
  );

  // Word RAM stand-in: combinational read, write on the rising edge.
  assign ramRdata = ram[ramAddr[11:2]];
  always @(posedge clk) begin
    if (ramWe) ram[ramAddr[11:2]] <= ramWdata;
  end

  function automatic logic obsGnt(input int p);
    return (p == 1) ? m1_gnt : m0_gnt;
  endfunction

  function automatic logic obsDone(input int p);
    return (p == 1) ? m1_done : m0_done;
  endfunction

  function automatic logic [31:0] obsRdata(input int p);
    return (p == 1) ? m1_rdata : m0_rdata;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
  endtask

  // Transaction-level model: decides the grant for the edge just passed.
  task automatic modelStep();
    int          w;
    int          lat;
    int          idx;
    txn_t        t;
    logic [31:0] old;
    logic [31:0] merged;
    bit          partial;
    if (wrValid && cyc >= wrAt) begin
      model[wrIdx] = wrData;
      wrValid = 1'b0;
    end
    if (cyc >= freeAt && reqPrev != 2'b00) begin
      if (reqPrev == 2'b11) w = lastPort ? 0 : 1;
      else w = reqPrev[1] ? 1 : 0;
      lastPort = (w == 1);
      t = pend[w];
      idx = int'(t.addr[11:2]);
      old = model[idx];
      partial = RMW && t.we && t.be != 4'h0 && t.be != 4'hF;
      lat = partial ? 3 : 2;
      gntAt = cyc;
      gntPort = w;
      doneAt[w] = cyc + lat - 1;
      doneRead[w] = !t.we;
      freeAt = cyc + lat;
      if (!t.we) begin
        expRd[w] = old;
      end else if (t.be != 4'h0) begin
        merged = t.wdata;
        if (partial) begin
          for (int i = 0; i < 4; i++) merged[8*i +: 8] = t.be[i] ? t.wdata[8*i +: 8] : old[8*i +: 8];
        end
        weAt = partial ? cyc + 1 : cyc;
        expWAddr = {t.addr[31:2], 2'b00};
        expWData = merged;
        wrValid = 1'b1;
        wrIdx = idx;
        wrData = merged;
        wrAt = doneAt[w];
      end
    end
  endtask

  task automatic compareCycle();
    for (int p = 0; p < 2; p++) begin
      if (doneAt[p] == cyc && doneRead[p]) heldRd[p] = expRd[p];
      checkOutput($sformatf("m%0d_gnt@%0d", p, cyc), 32'(obsGnt(p)), 32'(gntAt == cyc && gntPort == p));
      checkOutput($sformatf("m%0d_done@%0d", p, cyc), 32'(obsDone(p)), 32'(doneAt[p] == cyc));
      checkOutput($sformatf("m%0d_rdata@%0d", p, cyc), obsRdata(p), heldRd[p]);
    end
    if (m0_gnt) gntLog.push_back(0);
    if (m1_gnt) gntLog.push_back(1);
    if (ramWe) weSeen = 1'b1;
    checkOutput($sformatf("ram_we@%0d", cyc), 32'(ramWe), 32'(weAt == cyc));
    if (weAt == cyc) begin
      checkOutput($sformatf("ram_addr@%0d", cyc), ramAddr, expWAddr);
      checkOutput($sformatf("ram_wdata@%0d", cyc), ramWdata, expWData);
    end
  endtask

  task automatic issue(input int p, input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    pend[p].we = w;
    pend[p].be = b;
    pend[p].addr = a;
    pend[p].wdata = d;
    weIn[p] = w;
    beIn[p] = b;
    addrIn[p] = a;
    wdataIn[p] = d;
    req[p] = 1'b1;
    busy[p] = 1'b1;
  endtask

  task automatic applyStimulus();
    logic [31:0] a;
    logic [3:0]  b;
    int          sel;
    if (gntAt == cyc) req[gntPort] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (doneAt[p] == cyc) busy[p] = 1'b0;
      if (randomOn && !busy[p] && $urandom_range(0, 2) == 0) begin
        sel = $urandom_range(0, 3);
        b = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom_range(0, 15));
        a = $urandom;
        a[11:2] = 10'd64 + 10'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 0) a[31:12] = 20'h0;
        issue(p, 1'($urandom_range(0, 1)), b, a, $urandom);
      end
    end
  endtask

  task automatic step();
    reqPrev = req;
    @(negedge clk);
    cyc++;
    modelStep();
    compareCycle();
    applyStimulus();
  endtask

  task automatic runIdle(input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      if (!busy[0] && !busy[1] && cyc + 1 >= freeAt) break;
      step();
    end
  endtask

  task automatic runTxn(input int p, input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, output int lat);
    int c0;
    bit seen;
    weSeen = 1'b0;
    issue(p, w, b, a, d);
    c0 = cyc;
    seen = 1'b0;
    lat = 99;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (obsDone(p)) begin
        seen = 1'b1;
        lat = cyc - c0;
      end
    end
    if (!seen) checkOutput($sformatf("m%0d_done_timeout", p), 32'(seen), 32'd1);
  endtask

  task automatic zeroCheck(input string tag);
    checkOutput({tag, "_m0_gnt"}, 32'(m0_gnt), 32'd0);
    checkOutput({tag, "_m1_gnt"}, 32'(m1_gnt), 32'd0);
    checkOutput({tag, "_m0_done"}, 32'(m0_done), 32'd0);
    checkOutput({tag, "_m1_done"}, 32'(m1_done), 32'd0);
    checkOutput({tag, "_ram_we"}, 32'(ramWe), 32'd0);
    checkOutput({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    checkOutput({tag, "_m1_rdata"}, m1_rdata, 32'd0);
    checkOutput({tag, "_ram_addr"}, ramAddr, 32'd0);
    checkOutput({tag, "_ram_wdata"}, ramWdata, 32'd0);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    req = 2'b00;
    freeAt = 0;
    gntAt = -1;
    weAt = -1;
    wrValid = 1'b0;
    lastPort = 1'b1;
    for (int p = 0; p < 2; p++) begin
      doneAt[p] = -1;
      doneRead[p] = 1'b0;
      heldRd[p] = 32'h0;
      busy[p] = 1'b0;
    end
    #1;
    zeroCheck("rst_async");
  endtask

  task automatic holdReset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      zeroCheck($sformatf("rst_hold%0d", i));
    end
  endtask

  task automatic checkFirst(input string tag, input int expected);
    checkOutput(tag, (gntLog.size() > 0) ? 32'(gntLog[0]) : 32'd99, 32'(expected));
  endtask

  initial begin
    int lat;
    req = 2'b00;
    for (int p = 0; p < 2; p++) begin
      weIn[p] = 1'b0;
      beIn[p] = 4'h0;
      addrIn[p] = 32'h0;
      wdataIn[p] = 32'h0;
    end
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 32'h0;
      model[i] = 32'h0;
    end

    // Reset with both ports requesting, then release: m0 then m1.
    applyReset();
    issue(0, 1'b0, 4'h0, 32'h100, 32'h0);
    issue(1, 1'b0, 4'h0, 32'h104, 32'h0);
    holdReset(3);
    rst_n = 1'b1;
    gntLog.delete();
    runIdle(20);
    checkOutput("rr_reset_count", 32'(gntLog.size()), 32'd2);
    checkFirst("rr_reset_first", 0);
    checkOutput("rr_reset_second", (gntLog.size() > 1) ? 32'(gntLog[1]) : 32'd99, 32'd1);

    // Fresh tie after m1 went last: m0 wins.
    gntLog.delete();
    issue(0, 1'b0, 4'h0, 32'h108, 32'h0);
    issue(1, 1'b0, 4'h0, 32'h10C, 32'h0);
    runIdle(20);
    checkFirst("rr_tie2_first", 0);

    // m1 alone, then a tie goes to m0.
    gntLog.delete();
    runTxn(1, 1'b0, 4'h0, 32'h110, 32'h0, lat);
    checkFirst("rr_m1_alone", 1);
    gntLog.delete();
    issue(0, 1'b0, 4'h0, 32'h100, 32'h0);
    issue(1, 1'b0, 4'h0, 32'h104, 32'h0);
    runIdle(20);
    checkFirst("rr_tie3_first", 0);

    // Full write then read back.
    runTxn(0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, lat);
    checkOutput("wr_full_lat", 32'(lat), 32'd2);
    runTxn(0, 1'b0, 4'h0, 32'h100, 32'h0, lat);
    checkOutput("rd_lat", 32'(lat), 32'd2);
    checkOutput("rd_data", m0_rdata, 32'hDEADBEEF);

    // Partial write: one byte lane.
    runTxn(0, 1'b1, 4'hF, 32'h200, 32'h11223344, lat);
    runTxn(0, 1'b1, 4'b0010, 32'h200, 32'h0000AA00, lat);
    checkOutput("partial_lat", 32'(lat), RMW ? 32'd3 : 32'd2);
    runTxn(0, 1'b0, 4'h0, 32'h200, 32'h0, lat);
    checkOutput("partial_data", m0_rdata, RMW ? 32'h1122AA44 : 32'h0000AA00);

    // Empty byte enables: no RAM write at all.
    runTxn(0, 1'b1, 4'hF, 32'h200, 32'h11223344, lat);
    runTxn(1, 1'b1, 4'h0, 32'h200, 32'hFFFFFFFF, lat);
    checkOutput("be0_no_we", 32'(weSeen), 32'd0);
    checkOutput("be0_lat", 32'(lat), 32'd2);
    runTxn(1, 1'b0, 4'h0, 32'h200, 32'h0, lat);
    checkOutput("be0_data", m1_rdata, 32'h11223344);

`ifdef DRAM_ARB_RMW_EN
    // Reset while in MERGE: write dropped, no done.
    issue(0, 1'b1, 4'b1000, 32'h200, 32'h55000000);
    step();
    step();
    checkOutput("merge_we_high", 32'(ramWe), 32'd1);
    applyReset();
    holdReset(2);
    rst_n = 1'b1;
    runTxn(0, 1'b0, 4'h0, 32'h200, 32'h0, lat);
    checkOutput("merge_rst_lat", 32'(lat), 32'd2);
    checkOutput("merge_rst_data", m0_rdata, 32'h11223344);
`endif

    // Randomized traffic on both ports.
    randomOn = 1'b1;
    for (int i = 0; i < 3000; i++) step();
    randomOn = 1'b0;
    runIdle(20);
    for (int i = 0; i < 1024; i++) begin
      if (model[i] !== 32'h0 || ram[i] !== 32'h0) checkOutput($sformatf("mem[%0d]", i), ram[i], model[i]);
    end
    checkOutput("mem[128]", ram[128], model[128]);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-port arbiter and sequencer in front of the single-port word data RAM in the riscv32i core. It shares the RAM between the core load/store unit (port 0) and a second requester such as a DMA or debug master (port 1), using round-robin arbitration. Each granted request is sequenced as one RAM access cycle, plus an optional read-modify-write cycle so byte-enable writes work on the word-only RAM. It sits between the requesters and data_ram and drives data_ram's we/addr/data_in.

## Interface
- `RAM_WORDS`, default 1024: RAM depth in words; addresses pass through unmodified, so the RAM wraps on its own index.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `mX_req` input 1 (X = 0, 1): request; held high until `mX_gnt` is seen.
- `mX_we` input 1: 1 = write, 0 = read.
- `mX_be` input 4: byte enables for writes; bit i covers bits [8i+7:8i]; ignored on reads.
- `mX_addr` input 32: byte address; bits [1:0] are ignored.
- `mX_wdata` input 32: write data.
- `mX_gnt` output 1: one-cycle pulse; the request has been latched.
- `mX_done` output 1: one-cycle pulse; the access is complete (reads and writes).
- `mX_rdata` output 32: read data, valid while `mX_done` is high after a read.
- `ram_we` output 1: to data_ram `we`.
- `ram_addr` output 32: to data_ram `addr`; latched address with [1:0] forced to 0.
- `ram_wdata` output 32: to data_ram `data_in`.
- `ram_rdata` input 32: from data_ram `data_out` (combinational read).

## Operation
- Registered FSM with three states: IDLE, ACCESS, MERGE. All outputs are registered.
- **IDLE, at least one req high**
  - Select the winner, then latch its we/be/addr/wdata and its port id.
  - Next state is ACCESS; assert the winner's `gnt` during ACCESS.
- **Arbitration**
  - A single requester always wins.
  - If both request, the port not granted last wins.
  - The last-grant pointer updates on every grant. After reset it points to port 1, so port 0 wins the first tie.
- **ACCESS**
  - `ram_addr` = latched address.
  - Read: capture `ram_rdata` into the port's `rdata`; go to IDLE with `done` high.
  - Write with be = 4'hF: `ram_we`=1, `ram_wdata`=wdata; go to IDLE with `done`.
  - Write with be = 0: no RAM write; go to IDLE with `done`.
  - Partial write (be neither 0 nor F): capture `ram_rdata` into the merge register; go to MERGE.
- **MERGE**
  - `ram_wdata` = enabled bytes from wdata, remaining bytes from the merge register; `ram_we`=1.
  - Go to IDLE with `done`.
- `done` goes only to the latched port. The other port's `rdata` holds its previous value.
- The arbiter accepts a new request in the same IDLE cycle in which `done` is high (back-to-back operation).
- `ram_we` is high only in ACCESS (full-word write) or MERGE, never in IDLE.
- Requesters must drop or change `req` at the edge after seeing `gnt`. A `req` still high in IDLE counts as a new request.
- Reset values: state IDLE; all `gnt`, `done`, `ram_we` = 0; all `rdata`, `ram_addr`, `ram_wdata` and latches = 0; pointer = port 1.
- Reset mid-operation:
  - All outputs clear asynchronously and the pending access is dropped.
  - No RAM write completes after `rst_n` falls, and no `done` is issued.

## Timing
- Cycle 0: req sampled in IDLE. Cycle 1: ACCESS, `gnt` high.
- Read, full-word write and be = 0 write: `done` in cycle 2, so latency is 2.
- Partial write: MERGE in cycle 2, `done` in cycle 3, so latency is 3.
- Peak throughput: one access every 2 cycles (3 for partial writes).
- Worst-case wait for a requester under continuous contention: one other access, at most 3 cycles, before its own grant.

## Configuration
- Macro `DRAM_ARB_RMW_EN`.
- Defined: partial writes use ACCESS then MERGE read-modify-write, as described above.
- Undefined:
  - MERGE state is not compiled; be is ignored except be = 0.
  - Every write with be ≠ 0 is a full-word write of wdata in ACCESS, with latency 2.

## Test plan
- **Reset:** hold `rst_n`=0 with both req high → all outputs 0 and no `gnt`. Release → `m0_gnt` pulses first.
- **Write then read:** m0 write 0x100 ← 0xDEADBEEF, be=F; then m0 read 0x100 → `gnt` in cycle 1, `done` in cycle 2, `m0_rdata`=0xDEADBEEF.
- **Round-robin:** both req reads from reset → grants in the order m0, then m1. A fresh tie → m0. m1 alone → m1. A tie after that → m0.
- **Partial write:** word 0x200 = 0x11223344; write be=4'b0010, wdata 0x0000AA00 → readback 0x1122AA44, `done` in cycle 3. With the macro undefined → readback 0x0000AA00, `done` in cycle 2.
- **Empty byte enables:** be=0 write to 0x200 → `ram_we` never high, `done` pulses, word still 0x11223344.
- **Reset during MERGE:** pull `rst_n` low in MERGE → `ram_we` drops at once, word unchanged, no `done`, state IDLE.
